// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage between the PC register and decode.
// Issues one fetch at a time over a req/ack handshake, buffers returned words
// in a small circular FIFO, and drives the PC register's stall input so the PC
// advances exactly once per issued fetch. A flush empties the FIFO and turns
// any outstanding fetch into a discarded one.
module ifetch_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam logic [AW:0]   DEPTH_CNT = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE   = 1;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [31:0]   addr_q;
    logic          issued_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_next;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];

    logic ack;
    logic push;
    logic pop;
    logic issue;

    assign imem_req   = (state_q != ST_IDLE);
    assign imem_addr  = addr_q;
    assign pc_stall   = !(issued_q || flush);
    assign inst_valid = (cnt_q != '0);
    assign inst       = fifo_inst[rd_ptr_q];
    assign inst_pc    = fifo_pc[rd_ptr_q];

    assign ack      = imem_req && imem_ack;
    assign push     = (state_q == ST_BUSY) && ack && !flush;
    assign pop      = inst_valid && inst_ready && !flush;
    assign cnt_next = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    // Issue only when the FIFO will still have room after this edge's push/pop,
    // so a returned word can never be pushed into a full FIFO.
    assign issue    = !flush && (cnt_next < DEPTH_CNT) &&
                      ((state_q == ST_IDLE) || ((state_q == ST_BUSY) && ack));

    // Next-state selection for the fetch handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (issue)      state_d = ST_BUSY;
                else if (ack)   state_d = ST_IDLE;
                else if (flush) state_d = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fetch state, captured fetch address and the one-cycle issue pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            issued_q <= issue;
            if (issue) addr_q <= pc;
        end
    end

    // Instruction FIFO: circular buffer of {fetch address, instruction word}.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (flush) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) begin
                fifo_inst[wr_ptr_q] <= imem_rdata;
                fifo_pc[wr_ptr_q]   <= addr_q;
                wr_ptr_q            <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cnt_q <= cnt_next;
        end
    end

endmodule
